mem_access_stage: RTL and testbench

//  MEM stage plus MEM/WB pipeline register, directly downstream of the EX/MEM register.

---
 rtl/mem_access_stage.sv | 204 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_access_stage                                             |
// | Description : MEM stage and MEM/WB pipeline register. Issues loads/stores  |
// |               to a variable-latency data memory over a req/ack handshake,  |
// |               stalls upstream while an access is outstanding, and flags    |
// |               misaligned accesses and bus timeouts (sticky).               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] readData2In,
  input  logic [31:0] adderIn,
  input  logic [4:0]  dataForWRIn,
  input  logic        regWriteIn,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic        memToRegIn,
  input  logic        JALIn,
  output logic        stallOut,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic [31:0] memRData,
  input  logic        memAck,
  output logic [31:0] ALUResultOut,
  output logic [31:0] memDataOut,
  output logic [31:0] adderOut,
  output logic [4:0]  dataForWROut,
  output logic        regWriteOut,
  output logic        memToRegOut,
  output logic        JALOut,
  output logic        busErrorOut,
  output logic        alignErrorOut
);

  // Last counter value before an unanswered access is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        memReq_q, memReq_d;
  logic        memWe_q, memWe_d;
  logic [31:0] memAddr_q, memAddr_d;
  logic [31:0] memWData_q, memWData_d;

  logic [31:0] aluRes_q, aluRes_d;
  logic [31:0] memData_q, memData_d;
  logic [31:0] adder_q, adder_d;
  logic [4:0]  destReg_q, destReg_d;
  logic        regWrite_q, regWrite_d;
  logic        memToReg_q, memToReg_d;
  logic        jal_q, jal_d;
  logic        busErr_q, busErr_d;
  logic        alignErr_q, alignErr_d;

  logic        mem_op;
  logic        misal;
  logic        cnt_last;

  assign mem_op   = memReadIn | memWriteIn;
  assign misal    = mem_op & (ALUResultIn[1:0] != 2'b00);
  assign cnt_last = (cnt_q == CNT_LAST);

  // Hold upstream while an access is being launched or is still waiting for its ack.
  assign stallOut = ((state_q == S_IDLE)   & mem_op & ~misal) |
                    ((state_q == S_ACCESS) & ~memAck & ~cnt_last);

  // Next-state, memory request and MEM/WB capture logic; a bubble is the default.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    memReq_d   = memReq_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWData_d = memWData_q;
    aluRes_d   = aluRes_q;
    memData_d  = memData_q;
    adder_d    = adder_q;
    destReg_d  = destReg_q;
    regWrite_d = 1'b0;
    memToReg_d = 1'b0;
    jal_d      = 1'b0;
    busErr_d   = busErr_q;
    alignErr_d = alignErr_q;

    case (state_q)
      S_IDLE: begin
        if (mem_op && !misal) begin
          // Launch the access; a simultaneous read+write is issued as a write.
          state_d    = S_ACCESS;
          cnt_d      = 8'd0;
          memReq_d   = 1'b1;
          memWe_d    = memWriteIn;
          memAddr_d  = ALUResultIn;
          memWData_d = readData2In;
        end else begin
          // Non-memory op or misaligned access passes straight into MEM/WB.
          aluRes_d   = ALUResultIn;
          adder_d    = adderIn;
          destReg_d  = dataForWRIn;
          regWrite_d = regWriteIn & ~misal;
          memToReg_d = memToRegIn & ~misal;
          jal_d      = JALIn;
          alignErr_d = alignErr_q | misal;
        end
      end

      S_ACCESS: begin
        if (memAck) begin
          state_d    = S_IDLE;
          memReq_d   = 1'b0;
          aluRes_d   = ALUResultIn;
          adder_d    = adderIn;
          destReg_d  = dataForWRIn;
          regWrite_d = regWriteIn;
          memToReg_d = memToRegIn;
          jal_d      = JALIn;
          if (!memWriteIn) begin
            memData_d = memRData;
          end
        end else if (cnt_last) begin
          // Abort: retire the instruction with its write-back suppressed.
          state_d    = S_IDLE;
          memReq_d   = 1'b0;
          busErr_d   = 1'b1;
          aluRes_d   = ALUResultIn;
          adder_d    = adderIn;
          destReg_d  = dataForWRIn;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, request and MEM/WB registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= 32'd0;
      memWData_q <= 32'd0;
      aluRes_q   <= 32'd0;
      memData_q  <= 32'd0;
      adder_q    <= 32'd0;
      destReg_q  <= 5'd0;
      regWrite_q <= 1'b0;
      memToReg_q <= 1'b0;
      jal_q      <= 1'b0;
      busErr_q   <= 1'b0;
      alignErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWData_q <= memWData_d;
      aluRes_q   <= aluRes_d;
      memData_q  <= memData_d;
      adder_q    <= adder_d;
      destReg_q  <= destReg_d;
      regWrite_q <= regWrite_d;
      memToReg_q <= memToReg_d;
      jal_q      <= jal_d;
      busErr_q   <= busErr_d;
      alignErr_q <= alignErr_d;
    end
  end

  assign memReq        = memReq_q;
  assign memWe         = memWe_q;
  assign memAddr       = memAddr_q;
  assign memWData      = memWData_q;
  assign ALUResultOut  = aluRes_q;
  assign memDataOut    = memData_q;
  assign adderOut      = adder_q;
  assign dataForWROut  = destReg_q;
  assign regWriteOut   = regWrite_q;
  assign memToRegOut   = memToReg_q;
  assign JALOut        = jal_q;
  assign busErrorOut   = busErr_q;
  assign alignErrorOut = alignErr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_access_stage                                          |
// | Description : Scoreboard bench for mem_access_stage with a memory          |
// |               responder and an instruction-level reference model.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResultIn, readData2In, adderIn;
  logic [4:0]  dataForWRIn;
  logic        regWriteIn, memReadIn, memWriteIn, memToRegIn, JALIn;
  logic        stallOut, memReq, memWe;
  logic [31:0] memAddr, memWData, memRData;
  logic        memAck;
  logic [31:0] ALUResultOut, memDataOut, adderOut;
  logic [4:0]  dataForWROut;
  logic        regWriteOut, memToRegOut, JALOut, busErrorOut, alignErrorOut;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ALUResultIn(ALUResultIn), .readData2In(readData2In), .adderIn(adderIn),
    .dataForWRIn(dataForWRIn), .regWriteIn(regWriteIn), .memReadIn(memReadIn),
    .memWriteIn(memWriteIn), .memToRegIn(memToRegIn), .JALIn(JALIn),
    .stallOut(stallOut), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
    .memWData(memWData), .memRData(memRData), .memAck(memAck),
    .ALUResultOut(ALUResultOut), .memDataOut(memDataOut), .adderOut(adderOut),
    .dataForWROut(dataForWROut), .regWriteOut(regWriteOut),
    .memToRegOut(memToRegOut), .JALOut(JALOut), .busErrorOut(busErrorOut),
    .alignErrorOut(alignErrorOut)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mdata;
    logic [31:0] adder;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic        jal;
    logic        bus;
    logic        align;
    logic [7:0]  stall;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        tb_valid = 1'b0;

  // Reference model state: last loaded word and sticky flags.
  logic [31:0] m_mdata = 32'd0;
  logic        m_bus   = 1'b0;
  logic        m_align = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic set_inputs(input logic [31:0] addr, wdata, adder, input logic [4:0] rd,
                            input logic rw, mr, mw, m2r, jal);
    ALUResultIn = addr; readData2In = wdata; adderIn = adder; dataForWRIn = rd;
    regWriteIn = rw; memReadIn = mr; memWriteIn = mw; memToRegIn = m2r; JALIn = jal;
  endtask

  // Present one instruction, answer its memory request after `delay` request
  // cycles (0 = never answer), and push the expected MEM/WB result.
  task automatic issue(input logic [31:0] addr, wdata, adder, input logic [4:0] rd,
                       input logic rw, mr, mw, m2r, jal,
                       input int delay, input logic [31:0] rdata);
    exp_t e;
    logic mem_op;
    logic misal;
    int   req_exp;
    int   acc;
    logic s;
    bit   done;
    mem_op = mr | mw;
    misal  = mem_op && (addr[1:0] != 2'b00);
    e.alu = addr; e.adder = adder; e.rd = rd; e.rw = rw; e.m2r = m2r; e.jal = jal;
    if (!mem_op || misal) begin
      if (misal) begin
        e.rw = 1'b0; e.m2r = 1'b0; m_align = 1'b1;
      end
      req_exp = 0;
    end else if (delay == 0) begin
      e.rw = 1'b0; e.m2r = 1'b0; e.jal = 1'b0; m_bus = 1'b1;
      req_exp = TO;
    end else begin
      if (!mw) m_mdata = rdata;
      req_exp = delay;
    end
    e.stall = 8'(req_exp);
    e.mdata = m_mdata; e.bus = m_bus; e.align = m_align;
    exp_q.push_back(e);

    set_inputs(addr, wdata, adder, rd, rw, mr, mw, m2r, jal);
    tb_valid = 1'b1;
    acc  = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (memReq) begin
        acc++;
        chk("memWe", {31'd0, memWe}, {31'd0, mw});
        chk("memAddr", memAddr, addr);
        chk("memWData", memWData, wdata);
      end
      memAck   = (delay != 0) && memReq && (acc == delay);
      memRData = memAck ? rdata : $urandom;
      #1;
      s = stallOut;
      @(negedge clk);
      if (!s) begin
        done = 1'b1;
        break;
      end
    end
    memAck = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL retire_timeout: instruction at addr %h never retired", addr);
    end
    chk("req_cycles", 32'(acc), 32'(req_exp));
    chk("memReq_after", {31'd0, memReq}, 32'd0);
  endtask

  // Monitor: classify each edge (reset / retire / bubble) and check the
  // MEM/WB outputs that follow it against the scoreboard.
  initial begin
    exp_t last;
    exp_t e;
    logic pend_rst, pend_ret, pend_bub;
    int   stall_cnt;
    last = '0; stall_cnt = 0;
    pend_rst = 1'b0; pend_ret = 1'b0; pend_bub = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (pend_rst) begin
        chk("rst_outs", {ALUResultOut | memDataOut | adderOut}, 32'd0);
        chk("rst_flags", {24'd0, memReq, memWe, regWriteOut, memToRegOut, JALOut,
                          busErrorOut, alignErrorOut, |dataForWROut}, 32'd0);
        chk("rst_bus", memAddr | memWData, 32'd0);
        last = '0; stall_cnt = 0;
      end else if (pend_ret) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL retire_unexpected: DUT retired with empty scoreboard at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("ALUResultOut", ALUResultOut, e.alu);
          chk("memDataOut", memDataOut, e.mdata);
          chk("adderOut", adderOut, e.adder);
          chk("dataForWROut", {27'd0, dataForWROut}, {27'd0, e.rd});
          chk("wb_ctrl", {29'd0, regWriteOut, memToRegOut, JALOut}, {29'd0, e.rw, e.m2r, e.jal});
          chk("err_flags", {30'd0, busErrorOut, alignErrorOut}, {30'd0, e.bus, e.align});
          chk("stall_cycles", 32'(stall_cnt), {24'd0, e.stall});
          last = e;
        end
        stall_cnt = 0;
      end else if (pend_bub) begin
        chk("bubble_ctrl", {29'd0, regWriteOut, memToRegOut, JALOut}, 32'd0);
        chk("bubble_hold", ALUResultOut ^ memDataOut, last.alu ^ last.mdata);
        chk("bubble_flags", {30'd0, busErrorOut, alignErrorOut}, {30'd0, last.bus, last.align});
        stall_cnt++;
      end
      pend_rst = !reset;
      pend_ret = reset && !stallOut && tb_valid;
      pend_bub = reset && stallOut && tb_valid;
    end
  end

  // Stimulus.
  initial begin
    int          op;
    logic [31:0] a;
    reset = 1'b0;
    memAck = 1'b0; memRData = 32'd0;
    set_inputs(32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_inputs($urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
      memAck = 1'($urandom); memRData = $urandom;
    end
    @(negedge clk);
    set_inputs(32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    memAck = 1'b0;
    #1;
    chk("stall_idle_reset", {31'd0, stallOut}, 32'd0);
    reset = 1'b1;

    // Directed cases.
    issue(32'h1234, 32'h0, 32'h8, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    issue(32'h100, 32'h0, 32'hC, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3, 32'hDEADBEEF);
    issue(32'h40, 32'hA5A5A5A5, 32'h10, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 32'h0);
    issue(32'h102, 32'h0, 32'h14, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 32'h11111111);
    issue(32'h200, 32'h0, 32'h18, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h0);
    issue(32'h300, 32'h0, 32'h1C, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2, 32'h22222222);

    // Randomised instruction mix.
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      a  = $urandom;
      if (op != 0) begin
        a[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end
      issue(a, $urandom, $urandom, 5'($urandom), 1'($urandom),
            (op == 1) || (op == 3), (op == 2) || (op == 3), 1'($urandom), 1'($urandom),
            $urandom_range(0, 4), $urandom);
    end

    // Reset in the middle of an access, then a late ack.
    tb_valid = 1'b0;
    set_inputs(32'h400, 32'h0, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("memReq_in_access", {31'd0, memReq}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("memReq_after_reset", {31'd0, memReq}, 32'd0);
    reset = 1'b1;
    set_inputs(32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    memAck = 1'b1; memRData = 32'hCAFEF00D;
    #1;
    chk("stall_late_ack", {31'd0, stallOut}, 32'd0);
    @(negedge clk);
    memAck = 1'b0;
    chk("late_ack_ignored", {28'd0, memReq, regWriteOut, busErrorOut, alignErrorOut}, 32'd0);
    chk("late_ack_data", memDataOut, 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
